// File: rtl/wb_mctrl_arb_pkg.sv
// Shared definitions for the WISHBONE memory-controller arbiter slice.
package wb_mctrl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_mctrl_arb_pick.sv
// Combinational round-robin picker: first requester strictly after the
// one-hot 'last' position, wrapping around to index 0.
module wb_rr_pick #(
    parameter int unsigned NM = 2
) (
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] last,
    output logic [NM-1:0] pick
);

    logic [NM-1:0] w_hi;
    logic [NM-1:0] w_hi_req;
    logic          w_seen;
    logic          w_found;

    // Split requests into those above 'last' (preferred) and the wrapped rest.
    always_comb begin
        w_hi     = '0;
        w_seen   = 1'b0;
        w_found  = 1'b0;
        pick     = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            w_hi[i] = w_seen;
            w_seen  = w_seen | last[i];
        end
        w_hi_req = req & w_hi;
        for (int unsigned i = 0; i < NM; i++) begin
            if (!w_found && w_hi_req[i]) begin
                pick[i] = 1'b1;
                w_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NM; i++) begin
            if (!w_found && req[i]) begin
                pick[i] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mctrl_arb.sv
// Round-robin WISHBONE arbiter in front of the memory controller slave port,
// with a stall watchdog that terminates hung accesses with an error.
module wb_mctrl_arb
    import wb_mctrl_arb_pkg::*;
#(
    parameter int unsigned NM   = 2,
    parameter int unsigned TOUT = 255,
    parameter int unsigned TW   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM*3-1:0]  m_cti_i,
    input  logic [NM*2-1:0]  m_bte_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_rty_o,
    output logic [31:0]      m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic [2:0]       s_cti_o,
    output logic [1:0]       s_bte_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic [31:0]      s_dat_i,
    output logic [NM-1:0]    gnt_o,
    output logic             tout_o,
    input  logic             tout_clr_i
);

    localparam logic [NM-1:0] LAST_RST = {1'b1, {(NM-1){1'b0}}};
    localparam logic [TW-1:0] WD_LAST  = TW'(TOUT - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [NM-1:0] r_gnt, w_gnt_nxt;
    logic [NM-1:0] r_last, w_last_nxt;
    logic [NM-1:0] w_pick;
    logic [TW-1:0] r_wd, w_wd_nxt;
    logic          r_first, w_first_nxt;
    logic          r_tout, w_tout_nxt;
    logic          w_resp;
    logic          w_gcyc;

    wb_rr_pick #(.NM(NM)) u_pick (
        .req  (m_cyc_i),
        .last (r_last),
        .pick (w_pick)
    );

    assign w_resp  = s_ack_i | s_err_i | s_rty_i;
    assign w_gcyc  = |(m_cyc_i & r_gnt);
    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;
    assign tout_o  = r_tout;

    // State, grant, round-robin pointer, watchdog and sticky timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_RST;
            r_wd    <= '0;
            r_first <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_wd    <= w_wd_nxt;
            r_first <= w_first_nxt;
            r_tout  <= w_tout_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold grant for the whole cycle, watchdog abort.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_wd_nxt    = r_wd;
        w_first_nxt = 1'b0;
        w_tout_nxt  = r_tout & ~tout_clr_i;
        case (r_state)
            ST_IDLE: begin
                w_wd_nxt = '0;
                if (|m_cyc_i) begin
                    w_gnt_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_gcyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_wd_nxt    = '0;
                end else if (w_resp) begin
                    w_wd_nxt = '0;
                end else if (s_stb_o) begin
                    if (r_wd == WD_LAST) begin
                        w_state_nxt = ST_ABORT;
                        w_wd_nxt    = '0;
                        w_first_nxt = 1'b1;
                        w_tout_nxt  = 1'b1;
                    end else begin
                        w_wd_nxt = r_wd + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                w_wd_nxt = '0;
                if (!w_gcyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_wd_nxt    = '0;
            end
        endcase
    end

    // Slave-side mux driven straight from the grant register; quiet outside BUSY.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (r_state == ST_BUSY) begin
            for (int unsigned k = 0; k < NM; k++) begin
                if (r_gnt[k]) begin
                    s_cyc_o = m_cyc_i[k];
                    s_stb_o = m_stb_i[k];
                    s_we_o  = m_we_i[k];
                    s_adr_o = m_adr_i[32*k +: 32];
                    s_dat_o = m_dat_i[32*k +: 32];
                    s_sel_o = m_sel_i[4*k +: 4];
                    s_cti_o = m_cti_i[3*k +: 3];
                    s_bte_o = m_bte_i[2*k +: 2];
                end
            end
        end
    end

    // Responses go to the granted master only; abort issues a single-cycle error.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (r_state == ST_BUSY) begin
            m_ack_o = r_gnt & {NM{s_ack_i}};
            m_err_o = r_gnt & {NM{s_err_i}};
            m_rty_o = r_gnt & {NM{s_rty_i}};
        end else if (r_state == ST_ABORT) begin
            m_err_o = r_gnt & {NM{r_first}};
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));

endmodule

// File: tb/tb_wb_mctrl_arb.sv
// Directed self-checking bench for wb_mctrl_arb (NM=2 and NM=3 instances, TOUT=8).
module tb_wb_mctrl_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // NM=2 instance
    logic [1:0]  m_cyc2, m_stb2, m_we2, m_ack2, m_err2, m_rty2, gnt2;
    logic [63:0] m_adr2, m_dat2;
    logic [7:0]  m_sel2;
    logic [5:0]  m_cti2;
    logic [3:0]  m_bte2;
    logic [31:0] m_dato2, s_adr2, s_dat2, s_dati2;
    logic        s_cyc2, s_stb2, s_we2, s_ack2, s_err2, s_rty2, tout2, tout_clr2;
    logic [3:0]  s_sel2;
    logic [2:0]  s_cti2;
    logic [1:0]  s_bte2;

    // NM=3 instance
    logic [2:0]  m_cyc3, m_stb3, m_we3, m_ack3, m_err3, m_rty3, gnt3;
    logic [95:0] m_adr3, m_dat3;
    logic [11:0] m_sel3;
    logic [8:0]  m_cti3;
    logic [5:0]  m_bte3;
    logic [31:0] m_dato3, s_adr3, s_dat3, s_dati3;
    logic        s_cyc3, s_stb3, s_we3, s_ack3, s_err3, s_rty3, tout3, tout_clr3;
    logic [3:0]  s_sel3;
    logic [2:0]  s_cti3;
    logic [1:0]  s_bte3;

    wb_mctrl_arb #(.NM(2), .TOUT(8), .TW(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc2), .m_stb_i(m_stb2), .m_we_i(m_we2), .m_adr_i(m_adr2),
        .m_dat_i(m_dat2), .m_sel_i(m_sel2), .m_cti_i(m_cti2), .m_bte_i(m_bte2),
        .m_ack_o(m_ack2), .m_err_o(m_err2), .m_rty_o(m_rty2), .m_dat_o(m_dato2),
        .s_cyc_o(s_cyc2), .s_stb_o(s_stb2), .s_we_o(s_we2), .s_adr_o(s_adr2),
        .s_dat_o(s_dat2), .s_sel_o(s_sel2), .s_cti_o(s_cti2), .s_bte_o(s_bte2),
        .s_ack_i(s_ack2), .s_err_i(s_err2), .s_rty_i(s_rty2), .s_dat_i(s_dati2),
        .gnt_o(gnt2), .tout_o(tout2), .tout_clr_i(tout_clr2)
    );

    wb_mctrl_arb #(.NM(3), .TOUT(8), .TW(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc3), .m_stb_i(m_stb3), .m_we_i(m_we3), .m_adr_i(m_adr3),
        .m_dat_i(m_dat3), .m_sel_i(m_sel3), .m_cti_i(m_cti3), .m_bte_i(m_bte3),
        .m_ack_o(m_ack3), .m_err_o(m_err3), .m_rty_o(m_rty3), .m_dat_o(m_dato3),
        .s_cyc_o(s_cyc3), .s_stb_o(s_stb3), .s_we_o(s_we3), .s_adr_o(s_adr3),
        .s_dat_o(s_dat3), .s_sel_o(s_sel3), .s_cti_o(s_cti3), .s_bte_o(s_bte3),
        .s_ack_i(s_ack3), .s_err_i(s_err3), .s_rty_i(s_rty3), .s_dat_i(s_dati3),
        .gnt_o(gnt3), .tout_o(tout3), .tout_clr_i(tout_clr3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        m_cyc2 = '0; m_stb2 = '0; s_ack2 = 1'b0; s_err2 = 1'b0; s_rty2 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        m_cyc2 = '0; m_stb2 = '0; m_we2 = '0; m_adr2 = '0; m_dat2 = '0;
        m_sel2 = '1; m_cti2 = '0; m_bte2 = '0;
        s_ack2 = 0; s_err2 = 0; s_rty2 = 0; s_dati2 = 32'hDEAD_BEEF; tout_clr2 = 0;
        m_cyc3 = '0; m_stb3 = '0; m_we3 = '0; m_adr3 = '0; m_dat3 = '0;
        m_sel3 = '1; m_cti3 = '0; m_bte3 = '0;
        s_ack3 = 0; s_err3 = 0; s_rty3 = 0; s_dati3 = 32'h0; tout_clr3 = 0;
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (gnt2 !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt2); end
        n_tests++; if ({s_cyc2, s_stb2, tout2} !== 3'b000) begin n_fail++; $display("FAIL rst_cyc_stb_tout: got %b want 000", {s_cyc2, s_stb2, tout2}); end
        n_tests++; if ({m_ack2, m_err2, m_rty2} !== 6'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 000000", {m_ack2, m_err2, m_rty2}); end
        n_tests++; if (m_dato2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_dat_bcast: got %h want deadbeef", m_dato2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        m_adr2 = {32'hB000_0004, 32'hA000_0000};
        m_cyc2 = 2'b11; m_stb2 = 2'b11;
        #1;
        n_tests++; if ({gnt2, s_cyc2} !== 3'b000) begin n_fail++; $display("FAIL rr_latency: got %b want 000", {gnt2, s_cyc2}); end
        tick();
        n_tests++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL rr_first_gnt: got %b want 01", gnt2); end
        n_tests++; if (s_adr2 !== 32'hA000_0000 || s_cyc2 !== 1'b1) begin n_fail++; $display("FAIL rr_mux_m0: got %h/%b want a0000000/1", s_adr2, s_cyc2); end
        s_ack2 = 1'b1;
        #1;
        n_tests++; if (m_ack2 !== 2'b01) begin n_fail++; $display("FAIL rr_ack_m0: got %b want 01", m_ack2); end
        tick();
        s_ack2 = 1'b0; m_cyc2 = 2'b10; m_stb2 = 2'b10;
        #1;
        n_tests++; if (s_cyc2 !== 1'b0) begin n_fail++; $display("FAIL rr_cyc_drop: got %b want 0", s_cyc2); end
        tick();
        n_tests++; if (gnt2 !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap: got %b want 00", gnt2); end
        tick();
        n_tests++; if (gnt2 !== 2'b10 || s_adr2 !== 32'hB000_0004) begin n_fail++; $display("FAIL rr_second_gnt: got %b/%h want 10/b0000004", gnt2, s_adr2); end
        idle2();
    endtask

    task automatic test_burst();
        logic [2:0] ctis [4];
        ctis[0] = 3'b010; ctis[1] = 3'b010; ctis[2] = 3'b010; ctis[3] = 3'b111;
        m_cyc2 = 2'b10; m_stb2 = 2'b10; m_cti2 = {3'b010, 3'b000};
        tick();
        m_cyc2 = 2'b11; m_stb2 = 2'b11;
        for (int b = 0; b < 4; b++) begin
            m_cti2 = {ctis[b], 3'b000};
            s_ack2 = 1'b1;
            #1;
            n_tests++; if (gnt2 !== 2'b10 || m_ack2 !== 2'b10) begin n_fail++; $display("FAIL burst_beat%0d: gnt %b ack %b want 10/10", b, gnt2, m_ack2); end
            n_tests++; if (s_cti2 !== ctis[b]) begin n_fail++; $display("FAIL burst_cti%0d: got %b want %b", b, s_cti2, ctis[b]); end
            tick();
        end
        s_ack2 = 1'b0; m_cyc2 = 2'b01; m_stb2 = 2'b01; m_cti2 = '0;
        #1;
        n_tests++; if (gnt2 !== 2'b10 || s_cyc2 !== 1'b0) begin n_fail++; $display("FAIL burst_release: got %b/%b want 10/0", gnt2, s_cyc2); end
        tick();
        n_tests++; if (gnt2 !== 2'b00) begin n_fail++; $display("FAIL burst_idle: got %b want 00", gnt2); end
        tick();
        n_tests++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL burst_next_m0: got %b want 01", gnt2); end
        idle2();
    endtask

    task automatic test_timeout();
        m_cyc2 = 2'b01; m_stb2 = 2'b01; m_we2 = 2'b00;
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (m_err2 !== 2'b00 || s_stb2 !== 1'b1) begin n_fail++; $display("FAIL tout_wait%0d: err %b stb %b want 00/1", i, m_err2, s_stb2); end
            tick();
        end
        n_tests++; if (m_err2 !== 2'b01 || tout2 !== 1'b1 || s_cyc2 !== 1'b0) begin n_fail++; $display("FAIL tout_abort: err %b tout %b cyc %b want 01/1/0", m_err2, tout2, s_cyc2); end
        tick();
        n_tests++; if (m_err2 !== 2'b00 || tout2 !== 1'b1) begin n_fail++; $display("FAIL tout_err_once: err %b tout %b want 00/1", m_err2, tout2); end
        tout_clr2 = 1'b1;
        tick();
        tout_clr2 = 1'b0;
        n_tests++; if (tout2 !== 1'b0 || gnt2 !== 2'b01 || s_cyc2 !== 1'b0) begin n_fail++; $display("FAIL tout_clr: tout %b gnt %b cyc %b want 0/01/0", tout2, gnt2, s_cyc2); end
        m_cyc2 = 2'b00; m_stb2 = 2'b00;
        tick();
        n_tests++; if (gnt2 !== 2'b00) begin n_fail++; $display("FAIL tout_release: got %b want 00", gnt2); end
        idle2();
    endtask

    task automatic test_late_ack();
        m_cyc2 = 2'b10; m_stb2 = 2'b10;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        s_ack2 = 1'b1;
        #1;
        n_tests++; if (m_ack2 !== 2'b10 || m_err2 !== 2'b00) begin n_fail++; $display("FAIL late_ack: ack %b err %b want 10/00", m_ack2, m_err2); end
        tick();
        s_ack2 = 1'b0; m_cyc2 = 2'b00; m_stb2 = 2'b00;
        #1;
        n_tests++; if (m_err2 !== 2'b00 || tout2 !== 1'b0 || gnt2 !== 2'b10) begin n_fail++; $display("FAIL late_ack_noabort: err %b tout %b gnt %b want 00/0/10", m_err2, tout2, gnt2); end
        idle2();
    endtask

    task automatic test_async_reset();
        m_cyc2 = 2'b01; m_stb2 = 2'b01; m_cti2 = {3'b000, 3'b010};
        tick();
        m_cyc2 = 2'b11; m_stb2 = 2'b11; s_ack2 = 1'b1;
        #1;
        n_tests++; if (m_ack2 !== 2'b01) begin n_fail++; $display("FAIL arst_pre_ack: got %b want 01", m_ack2); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({gnt2, s_cyc2, s_stb2, tout2} !== 5'b0 || s_adr2 !== 32'h0 || s_cti2 !== 3'b000) begin n_fail++; $display("FAIL arst_outputs: gnt %b cyc %b stb %b tout %b adr %h", gnt2, s_cyc2, s_stb2, tout2, s_adr2); end
        n_tests++; if ({m_ack2, m_err2, m_rty2} !== 6'b0) begin n_fail++; $display("FAIL arst_resp: got %b want 000000", {m_ack2, m_err2, m_rty2}); end
        s_ack2 = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        n_tests++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL arst_priority: got %b want 01", gnt2); end
        m_cti2 = '0;
        idle2();
    endtask

    task automatic test_three_masters();
        logic [2:0] exp_gnt;
        m_adr3 = {32'h3000_0200, 32'h2000_0100, 32'h1000_0000};
        m_cyc3 = 3'b111; m_stb3 = 3'b111;
        tick();
        for (int i = 0; i < 6; i++) begin
            exp_gnt = 3'b001 << (i % 3);
            s_ack3 = 1'b1;
            #1;
            n_tests++; if (gnt3 !== exp_gnt || m_ack3 !== exp_gnt) begin n_fail++; $display("FAIL rr3_gnt%0d: gnt %b ack %b want %b", i, gnt3, m_ack3, exp_gnt); end
            n_tests++; if (s_adr3 !== m_adr3[32*(i%3) +: 32]) begin n_fail++; $display("FAIL rr3_adr%0d: got %h want %h", i, s_adr3, m_adr3[32*(i%3) +: 32]); end
            tick();
            s_ack3 = 1'b0;
            m_cyc3 = m_cyc3 & ~exp_gnt; m_stb3 = m_stb3 & ~exp_gnt;
            tick();
            m_cyc3 = 3'b111; m_stb3 = 3'b111;
            tick();
        end
        m_cyc3 = '0; m_stb3 = '0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_timeout();
        test_late_ack();
        test_async_reset();
        test_three_masters();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
